// File: rtl/distributor_18.sv
// One-to-eight byte distributor: valid/ready byte input steered into eight held
// channel registers by explicit select or auto pointer. Optional: DISTRIBUTOR_18_OVERRUN_EN.
module distributor_18 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic [2:0] in_sel,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       auto_mode,
  input  logic       clear,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [7:0] out4,
  output logic [7:0] out5,
  output logic [7:0] out6,
  output logic [7:0] out7,
  output logic [7:0] out_strobe,
  output logic [2:0] ptr,
`ifdef DISTRIBUTOR_18_OVERRUN_EN
  output logic [7:0] filled,
  output logic       overrun,
`endif
  output logic       frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t     r_state;
  logic       r_ready;
  logic [7:0] r_ch [8];
  logic [2:0] r_ptr;
  logic [2:0] r_flush_cnt;
  logic [7:0] r_strobe;
  logic       r_frame_done;

  logic       w_accept;
  logic [2:0] w_dest;

  assign w_accept = in_valid & r_ready;
  assign w_dest   = auto_mode ? r_ptr : in_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_ptr        <= '0;
      r_flush_cnt  <= '0;
      r_strobe     <= '0;
      r_frame_done <= 1'b0;
      // NOTE: the channel array is visible state on the ports, so every entry is reset, unlike a RAM.
      for (int k = 0; k < 8; k++) r_ch[k] <= '0;
    end else begin
      r_strobe     <= '0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_RUN;
          r_ready <= 1'b1;
        end
        S_RUN: begin
          // The write completes even when clear arrives in the same cycle.
          if (w_accept) begin
            r_ch[w_dest] <= in_data;
            r_strobe     <= 8'b1 << w_dest;
            if (auto_mode) begin
              r_ptr        <= r_ptr + 3'd1;
              r_frame_done <= (r_ptr == 3'd7);
            end
          end
          if (clear) begin
            r_state     <= S_FLUSH;
            r_ready     <= 1'b0;
            r_flush_cnt <= '0;
          end
        end
        S_FLUSH: begin
          r_ch[r_flush_cnt] <= '0;
          r_flush_cnt       <= r_flush_cnt + 3'd1;
          if (r_flush_cnt == 3'd7) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
            r_ptr   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef DISTRIBUTOR_18_OVERRUN_EN
  logic [7:0] r_filled;
  logic       r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_filled  <= '0;
      r_overrun <= 1'b0;
    end else if (r_state == S_RUN && w_accept) begin
      r_filled[w_dest] <= 1'b1;
      if (r_filled[w_dest]) r_overrun <= 1'b1;
    end else if (r_state == S_FLUSH) begin
      r_filled[r_flush_cnt] <= 1'b0;
      if (r_flush_cnt == 3'd7) r_overrun <= 1'b0;
    end
  end

  assign filled  = r_filled;
  assign overrun = r_overrun;
`endif

  assign in_ready   = r_ready;
  assign out0       = r_ch[0];
  assign out1       = r_ch[1];
  assign out2       = r_ch[2];
  assign out3       = r_ch[3];
  assign out4       = r_ch[4];
  assign out5       = r_ch[5];
  assign out6       = r_ch[6];
  assign out7       = r_ch[7];
  assign out_strobe = r_strobe;
  assign ptr        = r_ptr;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_distributor_18.sv
// Directed self-checking bench for distributor_18; expected values are hand-derived
// and tracked in a small per-channel expectation array.
module tb_distributor_18;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic       auto_mode;
  logic       clear;
  logic [7:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0] out_strobe;
  logic [2:0] ptr;
  logic       frame_done;
`ifdef DISTRIBUTOR_18_OVERRUN_EN
  logic [7:0] filled;
  logic       overrun;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] outs    [8];
  logic [7:0] exp_ch  [8];

  always #5 clk = ~clk;

  distributor_18 dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .auto_mode  (auto_mode),
    .clear      (clear),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out4       (out4),
    .out5       (out5),
    .out6       (out6),
    .out7       (out7),
    .out_strobe (out_strobe),
    .ptr        (ptr),
`ifdef DISTRIBUTOR_18_OVERRUN_EN
    .filled     (filled),
    .overrun    (overrun),
`endif
    .frame_done (frame_done)
  );

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;
  assign outs[4] = out4;
  assign outs[5] = out5;
  assign outs[6] = out6;
  assign outs[7] = out7;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_chans(input string tag);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s out%0d", tag, k), {24'd0, outs[k]}, {24'd0, exp_ch[k]});
  endtask

  // Advance one rising edge, then settle just after it for sampling and driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0;
    auto_mode = 1'b0; clear = 1'b0;
    for (int k = 0; k < 8; k++) exp_ch[k] = '0;

    // Reset for two cycles
    tick(); tick();
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    check("reset strobe", {24'd0, out_strobe}, 32'd0);
    check("reset ptr", {29'd0, ptr}, 32'd0);
    check("reset frame_done", {31'd0, frame_done}, 32'd0);
    check_chans("reset");

    rst = 1'b0;
    tick();
    check("post-reset ready", {31'd0, in_ready}, 32'd1);

    // Explicit write 0xA5 to channel 3
    in_valid = 1'b1; in_sel = 3'd3; in_data = 8'hA5;
    tick();
    exp_ch[3] = 8'hA5;
    check("sel write strobe", {24'd0, out_strobe}, 32'h08);
    check("sel write ptr", {29'd0, ptr}, 32'd0);
    check_chans("sel write");
    in_valid = 1'b0;
    tick();
    check("sel write strobe clears", {24'd0, out_strobe}, 32'h00);

    // Auto frame of 0x10..0x17
    auto_mode = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = 8'h10 + 8'(k);
      tick();
      exp_ch[k] = 8'h10 + 8'(k);
      check($sformatf("auto strobe %0d", k), {24'd0, out_strobe}, 32'd1 << k);
      check($sformatf("auto frame_done %0d", k), {31'd0, frame_done}, (k == 7) ? 32'd1 : 32'd0);
      check($sformatf("auto ptr %0d", k), {29'd0, ptr}, 32'((k + 1) % 8));
    end
    check_chans("auto frame");
    in_valid = 1'b0;
    tick();
    check("frame_done one pulse", {31'd0, frame_done}, 32'd0);
    check("after frame strobe", {24'd0, out_strobe}, 32'd0);

    // Mode switch: auto 0..2, explicit sel 6, back to auto lands on 3
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'h20 + 8'(k);
      tick();
      exp_ch[k] = 8'h20 + 8'(k);
    end
    check("mode ptr after 3", {29'd0, ptr}, 32'd3);
    auto_mode = 1'b0; in_sel = 3'd6; in_data = 8'h66;
    tick();
    exp_ch[6] = 8'h66;
    check("mode sel6 strobe", {24'd0, out_strobe}, 32'h40);
    check("mode ptr held", {29'd0, ptr}, 32'd3);
    auto_mode = 1'b1; in_data = 8'h33;
    tick();
    exp_ch[3] = 8'h33;
    check("mode resume strobe", {24'd0, out_strobe}, 32'h08);
    check("mode resume ptr", {29'd0, ptr}, 32'd4);
    check_chans("mode switch");

    // Stall: valid held, clear in same cycle; the byte lands at channel 4
    in_data = 8'h44; clear = 1'b1;
    tick();
    exp_ch[4] = 8'h44;
    clear = 1'b0;
    check("clear write strobe", {24'd0, out_strobe}, 32'h10);
    check("clear ready low", {31'd0, in_ready}, 32'd0);
    check_chans("clear write");
    for (int j = 1; j <= 8; j++) begin
      clear = (j == 3);
      tick();
      exp_ch[j-1] = '0;
      check($sformatf("flush %0d strobe", j), {24'd0, out_strobe}, 32'd0);
      check($sformatf("flush %0d ready", j), {31'd0, in_ready}, (j == 8) ? 32'd1 : 32'd0);
      check($sformatf("flush %0d chan", j-1), {24'd0, outs[j-1]}, 32'd0);
    end
    in_valid = 1'b0; clear = 1'b0;
    check_chans("flush done");
    check("flush ptr zero", {29'd0, ptr}, 32'd0);
    tick();
    check("no strobe after flush", {24'd0, out_strobe}, 32'd0);

    // Reset mid-FLUSH: ptr=1, ch5=0x55, then clear and reset at flush cycle 4
    in_valid = 1'b1; auto_mode = 1'b1; in_data = 8'h01;
    tick();
    auto_mode = 1'b0; in_sel = 3'd5; in_data = 8'h55;
    tick();
    check("pre-reset ptr", {29'd0, ptr}, 32'd1);
    check("pre-reset out5", {24'd0, out5}, 32'h55);
    in_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) exp_ch[k] = '0;
    check_chans("mid-flush reset");
    check("mid-flush reset ptr", {29'd0, ptr}, 32'd0);
    check("mid-flush reset ready", {31'd0, in_ready}, 32'd0);
    check("mid-flush reset strobe", {24'd0, out_strobe}, 32'd0);
    tick();
    check("idle then run", {31'd0, in_ready}, 32'd1);

    // A fresh flush must last the full 8 cycles from counter 0
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int j = 1; j <= 7; j++) tick();
    check("fresh flush ready at 7", {31'd0, in_ready}, 32'd0);
    tick();
    check("fresh flush ready at 8", {31'd0, in_ready}, 32'd1);

`ifdef DISTRIBUTOR_18_OVERRUN_EN
    check("ovr initial filled", {24'd0, filled}, 32'd0);
    in_valid = 1'b1; auto_mode = 1'b0; in_sel = 3'd2; in_data = 8'h22;
    tick();
    check("ovr first filled", {24'd0, filled}, 32'h04);
    check("ovr first overrun", {31'd0, overrun}, 32'd0);
    tick();
    check("ovr second overrun", {31'd0, overrun}, 32'd1);
    in_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int j = 1; j <= 8; j++) tick();
    check("ovr filled after flush", {24'd0, filled}, 32'd0);
    check("ovr overrun after flush", {31'd0, overrun}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
